// File: rtl/instr_fetch_decode_if.sv
// rtl/instr_fetch_decode_if.sv - instruction memory read port (req/ready)
interface instr_fetch_decode_if #(
  parameter int ADDR_W = 64
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - fetches one instruction per request and presents its decoded fields
module instr_fetch_decode #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    pc,
  input  logic                 fetch_start,
  instr_fetch_decode_if.master imem,
  output logic                 busy,
  output logic                 instr_valid,
  output logic [6:0]           Op,
  output logic [4:0]           rd,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [2:0]           funct3,
  output logic [6:0]           funct7,
  output logic [63:0]          imm,
  output logic                 illegal,
  output logic                 misaligned,
  output logic                 timeout_err
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DECODE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [31:0] ir;
  logic [63:0] imm_dec;
  logic        illegal_dec;
  logic        start_any, start_ok, start_bad, xfer, expire;

  assign start_any = (state == S_IDLE) && fetch_start;
  assign start_ok  = start_any && (pc[1:0] == 2'b00);
  assign start_bad = start_any && (pc[1:0] != 2'b00);
  assign xfer      = (state == S_REQ) && imem.imem_ready;
  // Fires on the TIMEOUT-th unanswered edge counted from the request edge.
  assign expire    = (state == S_REQ) && !imem.imem_ready && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_ok) state_nxt = S_REQ;
      S_REQ:    if (xfer) state_nxt = S_DECODE;
                else if (expire) state_nxt = S_IDLE;
      S_DECODE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != S_IDLE);
    imem.imem_req = (state == S_REQ);
  end

  always_comb begin
    imm_dec     = '0;
    illegal_dec = 1'b0;
    case (ir[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011:
        imm_dec = {{52{ir[31]}}, ir[31:20]};
      7'b0100011: imm_dec = {{52{ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011: imm_dec = {{52{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm_dec = {{32{ir[31]}}, ir[31:12], 12'b0};
      7'b1101111: imm_dec = {{44{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      7'b0110011, 7'b0111011: imm_dec = '0;
      default: illegal_dec = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      imem.imem_addr <= '0;
      wait_cnt       <= '0;
      ir             <= '0;
      instr_valid    <= 1'b0;
      Op             <= '0;
      rd             <= '0;
      rs1            <= '0;
      rs2            <= '0;
      funct3         <= '0;
      funct7         <= '0;
      imm            <= '0;
      illegal        <= 1'b0;
      misaligned     <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      if (start_any) begin
        instr_valid <= start_bad;
        misaligned  <= start_bad;
        illegal     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (start_ok) begin
        imem.imem_addr <= pc;
        wait_cnt       <= '0;
      end
      // A misaligned request completes immediately with an all-zero instruction.
      if (start_bad) begin
        Op     <= '0;
        rd     <= '0;
        rs1    <= '0;
        rs2    <= '0;
        funct3 <= '0;
        funct7 <= '0;
        imm    <= '0;
      end
      if (state == S_REQ && !imem.imem_ready) wait_cnt <= wait_cnt + 8'd1;
      if (xfer) ir <= imem.imem_rdata;
      if (expire) timeout_err <= 1'b1;
      if (state == S_DECODE) begin
        Op          <= ir[6:0];
        rd          <= ir[11:7];
        rs1         <= ir[19:15];
        rs2         <= ir[24:20];
        funct3      <= ir[14:12];
        funct7      <= ir[31:25];
        imm         <= imm_dec;
        illegal     <= illegal_dec;
        instr_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - randomized fetch/decode bench against a behavioural decoder model
module tb_instr_fetch_decode;
  localparam int ADDR_W  = 64;
  localparam int TIMEOUT = 4;
  localparam logic [6:0] OPS [14] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
                                      7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h00};

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic              fetch_start = 1'b0;
  logic              busy, instr_valid, illegal, misaligned, timeout_err;
  logic [6:0]        Op, funct7;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [63:0]       imm;
  int                errors = 0;
  int                checks = 0;
  int                xfers = 0;

  instr_fetch_decode_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_decode #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .pc(pc), .fetch_start(fetch_start), .imem(bus),
    .busy(busy), .instr_valid(instr_valid), .Op(Op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .illegal(illegal),
    .misaligned(misaligned), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (bus.imem_req && bus.imem_ready) xfers <= xfers + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w);
    exp_t        e;
    logic [11:0] s12;
    logic [12:0] b13;
    logic [20:0] j21;
    longint      v;
    e.op = w[6:0]; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.f3 = w[14:12]; e.f7 = w[31:25]; e.ill = 1'b0; v = 0;
    if (w[6:0] inside {7'h03, 7'h13, 7'h1B, 7'h67, 7'h73}) begin
      s12 = w[31:20]; v = $signed(s12);
    end else if (w[6:0] == 7'h23) begin
      s12 = {w[31:25], w[11:7]}; v = $signed(s12);
    end else if (w[6:0] == 7'h63) begin
      b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; v = $signed(b13);
    end else if (w[6:0] inside {7'h37, 7'h17}) begin
      v = $signed(w[31:12]); v = v * 4096;
    end else if (w[6:0] == 7'h6F) begin
      j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; v = $signed(j21);
    end else if (!(w[6:0] inside {7'h33, 7'h3B})) begin
      e.ill = 1'b1;
    end
    e.imm = v;
    return e;
  endfunction

  task automatic check_fields(input string tag, input exp_t e);
    check_eq({tag, "_op"}, Op, e.op);
    check_eq({tag, "_rd"}, rd, e.rd);
    check_eq({tag, "_rs1"}, rs1, e.rs1);
    check_eq({tag, "_rs2"}, rs2, e.rs2);
    check_eq({tag, "_f3"}, funct3, e.f3);
    check_eq({tag, "_f7"}, funct7, e.f7);
    check_eq({tag, "_imm"}, imm, e.imm);
    check_eq({tag, "_ill"}, illegal, e.ill);
  endtask

  // Aligned fetch with `waits` unanswered cycles; optionally pokes fetch_start while busy.
  task automatic fetch(input logic [63:0] a, input logic [31:0] w, input int waits, input bit poke);
    int x0;
    x0 = xfers;
    bus.imem_rdata = w; bus.imem_ready = 1'b0;
    @(negedge clock); pc = a; fetch_start = 1'b1;
    @(negedge clock); fetch_start = 1'b0;
    check_eq("e0_req", bus.imem_req, 1'b1);
    check_eq("e0_addr", bus.imem_addr, a);
    check_eq("e0_busy", busy, 1'b1);
    check_eq("e0_valid", instr_valid, 1'b0);
    check_eq("e0_terr", timeout_err, 1'b0);
    if (poke) begin fetch_start = 1'b1; pc = a + 64'h40; end
    for (int i = 0; i < waits; i++) begin
      @(negedge clock); fetch_start = 1'b0;
      check_eq("wait_req", bus.imem_req, 1'b1);
      check_eq("wait_addr", bus.imem_addr, a);
    end
    bus.imem_ready = 1'b1;
    @(negedge clock); fetch_start = 1'b0; bus.imem_ready = 1'b0;
    check_eq("dec_req", bus.imem_req, 1'b0);
    check_eq("dec_busy", busy, 1'b1);
    check_eq("dec_valid", instr_valid, 1'b0);
    @(negedge clock);
    check_eq("done_valid", instr_valid, 1'b1);
    check_eq("done_busy", busy, 1'b0);
    check_eq("done_xfers", xfers - x0, 1);
    check_fields("fld", model(w));
  endtask

  initial begin
    exp_t        e;
    logic [31:0] r, w;
    int          pick;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0;
    repeat (2) @(negedge clock);
    check_eq("rst_req", bus.imem_req, 1'b0);
    check_eq("rst_addr", bus.imem_addr, 64'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_imm", imm, 64'h0);
    check_eq("rst_flags", {illegal, misaligned, timeout_err}, 3'b000);
    reset = 1'b1;
    @(negedge clock);

    fetch(64'h100, 32'h00A00093, 0, 1'b0);
    check_eq("addi_imm", imm, 64'd10);
    check_eq("addi_rd", rd, 5'd1);
    check_eq("addi_op", Op, 7'h13);

    fetch(64'h200, 32'hFE000EE3, 3, 1'b0);
    check_eq("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("beq_f3", funct3, 3'd0);

    // Timeout: memory never answers.
    @(negedge clock); pc = 64'h300; fetch_start = 1'b1; bus.imem_ready = 1'b0;
    @(negedge clock); fetch_start = 1'b0;
    check_eq("to_e0_valid", instr_valid, 1'b0);
    for (int i = 1; i < TIMEOUT; i++) begin
      @(negedge clock);
      check_eq("to_wait_req", bus.imem_req, 1'b1);
      check_eq("to_wait_terr", timeout_err, 1'b0);
    end
    @(negedge clock);
    check_eq("to_req", bus.imem_req, 1'b0);
    check_eq("to_terr", timeout_err, 1'b1);
    check_eq("to_busy", busy, 1'b0);
    check_eq("to_valid", instr_valid, 1'b0);
    fetch(64'h304, 32'h00000033, 1, 1'b0);
    check_eq("to_cleared", timeout_err, 1'b0);

    // Misaligned pc.
    @(negedge clock); pc = 64'h102; fetch_start = 1'b1;
    @(negedge clock); fetch_start = 1'b0;
    check_eq("mis_flag", misaligned, 1'b1);
    check_eq("mis_valid", instr_valid, 1'b1);
    check_eq("mis_req", bus.imem_req, 1'b0);
    check_eq("mis_busy", busy, 1'b0);
    check_eq("mis_op", Op, 7'h0);
    check_eq("mis_imm", imm, 64'h0);

    fetch(64'h400, 32'h0000007F, 0, 1'b0);
    check_eq("ill_flag", illegal, 1'b1);
    check_eq("ill_mis", misaligned, 1'b0);
    check_eq("ill_imm", imm, 64'h0);

    // Randomized fetches, some with an ignored start while busy, ready noise while idle.
    for (int n = 0; n < 40; n++) begin
      r = $urandom(); pick = $urandom_range(0, 17);
      w = (pick < 14) ? {r[31:7], OPS[pick]} : r;
      fetch({$urandom(), $urandom()} & ~64'h3, w, $urandom_range(0, TIMEOUT - 1), ($urandom_range(0, 3) == 0));
      e = model(w);
      repeat ($urandom_range(1, 3)) begin
        @(negedge clock); bus.imem_ready = $urandom_range(0, 1); bus.imem_rdata = $urandom();
      end
      @(negedge clock); bus.imem_ready = 1'b0;
      check_eq("hold_valid", instr_valid, 1'b1);
      check_eq("hold_busy", busy, 1'b0);
      check_fields("hold", e);
    end

    // Reset in the middle of REQ, then a late ready while idle.
    @(negedge clock); pc = 64'h500; fetch_start = 1'b1; bus.imem_ready = 1'b0;
    @(negedge clock); fetch_start = 1'b0;
    check_eq("mr_req_before", bus.imem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("mr_req", bus.imem_req, 1'b0);
    check_eq("mr_addr", bus.imem_addr, 64'h0);
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_valid", instr_valid, 1'b0);
    check_eq("mr_imm", imm, 64'h0);
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h00A00093;
    @(negedge clock); reset = 1'b1;
    pick = xfers;
    repeat (2) @(negedge clock);
    check_eq("late_valid", instr_valid, 1'b0);
    check_eq("late_busy", busy, 1'b0);
    check_eq("late_xfers", xfers - pick, 0);
    bus.imem_ready = 1'b0;
    fetch(64'h600, 32'h12345037, 2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
